// File: rtl/tt_um_crc3.sv
// -----------------------------------------------------------------------------
// tt_um_crc3 -- serial CRC-3 generator (x^3 + x + 1) for a TinyTapeout tile.
//
// A frame is 8 serial bits, MSB first: 5 message bits followed by 3 zero pad
// bits. When the frame completes, the registered result
// {message[4:0], crc[2:0]} appears on uo_out one clock later. It holds there
// until the next completed frame.
//
// All state sits behind three latch-based clock gates:
//   G1 (crc, cnt, done, frame tag) and G2 (hist) run only while a frame is
//   being shifted in or while there is state to clear. G3 (uo_out, loaded
//   tag) runs exactly once per completed frame.
//
// Ports
//   clk      in   1  single clock; flops see gated copies only
//   rst_n    in   1  async active-low reset, applied directly to every flop
//   ui_in    in   8  [0] en (frame active), [1] serial data bit, [7:2] unused
//   uo_out   out  8  registered result {msg[4:0], crc[2:0]}
//   uio_in   in   8  unused
//   uio_out  out  8  tied 8'h00
//   uio_oe   out  8  tied 8'h00 (all bidirectionals are inputs)
//   ena      in   1  tile enable, ignored
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// tt_um_crc3_icg -- latch-based integrated clock gate.
//
// Ports
//   clk_i   in   1  free-running clock
//   en_i    in   1  gate enable, evaluated in the cycle before the edge it
//                   controls
//   gclk_o  out  1  gated clock; stays low while the enable is low
// -----------------------------------------------------------------------------
module tt_um_crc3_icg (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);

    logic en_latch;

    // NOTE: this latch is intentional. It is transparent only while clk is
    // low, so an enable that changes during the high phase cannot chop the
    // gated clock pulse.
    always_latch begin
        if (!clk_i) begin
            en_latch <= en_i;
        end
    end

    assign gclk_o = clk_i & en_latch;

endmodule

module tt_um_crc3 #(
    parameter logic [2:0] POLY = 3'b011   // feedback taps; x^3 is implicit
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    // The frame layout (5 message + 3 pad bits, 8-bit history) is fixed by
    // the output format, so the frame length is not a free parameter.
    localparam logic [3:0] FRAME_BITS = 4'd8;
    localparam logic [3:0] LAST_BIT   = FRAME_BITS - 4'd1;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic en;
    logic data_bit;

    assign en       = ui_in[0];
    assign data_bit = ui_in[1];

    // Unused inputs are folded into one named sink so lint sees them consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:2], uio_in, ena};

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // G1 domain
    logic [2:0] crc_q,   crc_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       done_q,  done_d;
    // Toggles once per completed frame; compared with loaded_tag_q to know
    // whether the current result has already reached uo_out.
    logic       frame_tag_q, frame_tag_d;

    // G2 domain
    logic [7:0] hist_q,  hist_d;

    // G3 domain
    logic [7:0] uo_out_q,  uo_out_d;
    logic       loaded_tag_q, loaded_tag_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic accept;
    logic fb;
    logic loaded;

    assign accept = en & ~done_q & (cnt_q < FRAME_BITS);
    assign fb     = crc_q[2];
    assign loaded = (frame_tag_q == loaded_tag_q);

    always_comb begin
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        frame_tag_d = frame_tag_q;
        hist_d      = hist_q;

        if (!en) begin
            // Abort / re-arm: dropping en clears everything but the result.
            crc_d  = 3'b000;
            cnt_d  = 4'd0;
            done_d = 1'b0;
            hist_d = 8'h00;
        end else if (accept) begin
            crc_d  = {crc_q[1:0], data_bit} ^ (fb ? POLY : 3'b000);
            hist_d = {hist_q[6:0], data_bit};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_BIT) begin
                done_d      = 1'b1;
                frame_tag_d = ~frame_tag_q;
            end
        end
    end

    // Output stage only ever runs when a new result is pending.
    always_comb begin
        uo_out_d     = {hist_q[7:3], crc_q};
        loaded_tag_d = frame_tag_q;
    end

    // ------------------------------------------------------------------
    // Clock gates
    // ------------------------------------------------------------------
    logic shift_en;
    logic out_en;
    logic gclk_crc;
    logic gclk_hist;
    logic gclk_out;

    // Run while shifting, or for the edge that clears leftover state.
    assign shift_en = (en & ~done_q) | (~en & ((cnt_q != 4'd0) | done_q));
    assign out_en   = done_q & ~loaded;

    tt_um_crc3_icg u_icg_crc (
        .clk_i  (clk),
        .en_i   (shift_en),
        .gclk_o (gclk_crc)
    );

    tt_um_crc3_icg u_icg_hist (
        .clk_i  (clk),
        .en_i   (shift_en),
        .gclk_o (gclk_hist)
    );

    tt_um_crc3_icg u_icg_out (
        .clk_i  (clk),
        .en_i   (out_en),
        .gclk_o (gclk_out)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: reset is on the flops' async pin, so it works even while every
    // gated clock is parked low.
    always_ff @(posedge gclk_crc or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= 3'b000;
            cnt_q       <= 4'd0;
            done_q      <= 1'b0;
            frame_tag_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            frame_tag_q <= frame_tag_d;
        end
    end

    always_ff @(posedge gclk_hist or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 8'h00;
        end else begin
            hist_q <= hist_d;
        end
    end

    always_ff @(posedge gclk_out or negedge rst_n) begin
        if (!rst_n) begin
            uo_out_q     <= 8'h00;
            loaded_tag_q <= 1'b0;
        end else begin
            uo_out_q     <= uo_out_d;
            loaded_tag_q <= loaded_tag_d;
        end
    end

    assign uo_out = uo_out_q;

endmodule

// File: tb/tb_tt_um_crc3.sv
module tb_tt_um_crc3;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int n_checks = 0;
    int n_fail   = 0;

    int n_g1 = 0;
    int n_g2 = 0;
    int n_g3 = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_result;

    tt_um_crc3 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge dut.gclk_crc)  n_g1++;
    always @(posedge dut.gclk_hist) n_g2++;
    always @(posedge dut.gclk_out)  n_g3++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: polynomial long division of the padded frame by 1011.
    function automatic logic [7:0] model(input logic [7:0] f);
        logic [7:0] r;
        r = f;
        for (int i = 7; i >= 3; i--) begin
            if (r[i]) r = r ^ (8'b0000_1011 << (i - 3));
        end
        return {f[7:3], r[2:0]};
    endfunction

    // One clock: drive, take the edge, settle 1 time unit past it.
    task automatic step(input logic en, input logic b);
        ui_in = {6'b000000, b, en};
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) step(1'b1, f[i]);
        exp_q.push_back(model(f));
    endtask

    // The result lands one edge after the 8th bit; en stays high so the
    // extra data bit must be ignored.
    task automatic expect_result(input string tag);
        logic [7:0] e;
        step(1'b1, 1'b1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(uo_out), 32'(e));
            last_result = e;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1_0, g2_0, g3_0;
        rst_n       = 1'b0;
        ui_in       = 8'h00;
        uio_in      = 8'h00;
        ena         = 1'b1;
        last_result = 8'h00;

        // 1. reset
        repeat (5) @(posedge clk);
        #1;
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("rst_uio_oe", 32'(uio_oe), 32'h00);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // 2. frame 10101000 -> AD, holds after en drops
        send_frame(8'b1010_1000);
        expect_result("frame_ad");
        check("frame_ad_const", 32'(uo_out), 32'hAD);
        step(1'b0, 1'b0);
        check("ad_hold_en_low", 32'(uo_out), 32'hAD);

        // 3. 11111000 -> FE, then all-zero frame -> 00
        send_frame(8'b1111_1000);
        expect_result("frame_fe");
        check("frame_fe_const", 32'(uo_out), 32'hFE);
        step(1'b0, 1'b0);
        send_frame(8'b0000_0000);
        expect_result("frame_00");
        step(1'b0, 1'b0);

        // 4. after completion, extra bits are ignored and G1/G2/G3 stay quiet
        send_frame(8'b1010_1000);
        expect_result("frame_ad_2");
        g1_0 = n_g1; g2_0 = n_g2; g3_0 = n_g3;
        repeat (4) step(1'b1, 1'b1);
        check("post_done_hold", 32'(uo_out), 32'hAD);
        check("post_done_g1", 32'(n_g1 - g1_0), 32'd0);
        check("post_done_g2", 32'(n_g2 - g2_0), 32'd0);
        check("post_done_g3", 32'(n_g3 - g3_0), 32'd0);
        step(1'b0, 1'b0);

        // 5. partial frame, abort, then full frame; no intermediate update
        send_frame(8'b1111_1000);
        expect_result("frame_fe_2");
        step(1'b0, 1'b0);
        g3_0 = n_g3;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("partial_hold", 32'(uo_out), 32'hFE);
        step(1'b0, 1'b0);
        check("abort_hold", 32'(uo_out), 32'hFE);
        check("abort_g3", 32'(n_g3 - g3_0), 32'd0);
        send_frame(8'b1010_1000);
        expect_result("after_abort");

        // en=0 on the edge that would take bit 8: abort wins
        step(1'b0, 1'b0);
        g3_0 = n_g3;
        for (int i = 7; i >= 1; i--) step(1'b1, model(8'b1111_1000) == 8'hFE ? 1'b1 : 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("abort_bit8_hold", 32'(uo_out), 32'(last_result));
        check("abort_bit8_g3", 32'(n_g3 - g3_0), 32'd0);

        // 6. async reset mid-frame, off a clock edge
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(uo_out), 32'h00);
        #3;
        ui_in = 8'h00;
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        send_frame(8'b1010_1000);
        expect_result("after_rst");

        // a few more message patterns through the scoreboard
        step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] f;
            f = {5'($urandom_range(0, 31)), 3'b000};
            send_frame(f);
            expect_result("rand_frame");
            step(1'b0, 1'b0);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
